// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter: accepts a WIDTH-bit word on load & ready and sends it LSB first on SDO.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data bits of every word.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clrb,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             SDO,
    output logic             valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
`else
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
`endif

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             r_state;
    // Bit 0 of the word goes straight to SDO, so only the remaining bits are kept here.
    logic [WIDTH-2:0]   r_shift;
    logic [CW-1:0]      r_cnt;
    logic               r_sdo;
    logic               r_valid;
    logic               r_done;
`ifdef PISO_PARITY_EN
    logic               r_par;
`endif
    logic               w_accept;

    assign ready    = (r_state == S_IDLE) | r_done;
    assign w_accept = load & ready;
    assign SDO      = r_sdo;
    assign valid    = r_valid;
    assign done     = r_done;

    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_sdo   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state <= S_SHIFT;
            r_shift <= din[WIDTH-1:1];
            r_sdo   <= din[0];
            r_valid <= 1'b1;
            r_done  <= 1'b0;
            r_cnt   <= CNT_LOAD;
`ifdef PISO_PARITY_EN
            r_par   <= ^din;
`endif
        end else if (r_state == S_SHIFT) begin
            if (r_cnt != '0) begin
                r_cnt   <= r_cnt - 1'b1;
                r_done  <= (r_cnt == CW'(1));
                r_shift <= r_shift >> 1;
`ifdef PISO_PARITY_EN
                // Data bits are exhausted when the counter reaches 1; the parity bit fills the last slot.
                r_sdo   <= (r_cnt == CW'(1)) ? r_par : r_shift[0];
`else
                r_sdo   <= r_shift[0];
`endif
            end else begin
                r_state <= S_IDLE;
                r_shift <= '0;
                r_sdo   <= 1'b0;
                r_valid <= 1'b0;
                r_done  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shifter: the transmit end of the team's serial-in right-shift register link.
- Accepts a WIDTH-bit word on a load handshake and drives it out one bit per clock, LSB first.
- A right-shift receiver clocked on the same edges, with its SDR input tied to SDO, holds the original word after WIDTH valid cycles.
- Sits between a parallel data source and the one-wire serial data path.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clrb  input  1  asynchronous active-low clear; clears all state immediately.
- load  input  1  request to accept din; sampled on the rising clk edge.
- din  input  WIDTH  parallel word; captured only when load and ready are both high.
- ready  output  1  combinational; high when a load will be accepted at the next edge.
- SDO  output  1  registered serial data out; LSB first.
- valid  output  1  registered; high while SDO carries a data (or parity) bit.
- done  output  1  registered; high during the final serial bit of a word.

Behaviour:
- Reset (clrb=0, asynchronous): state=IDLE, shift register=0, counter=0, SDO=0, valid=0, done=0. Reset takes effect immediately and overrides everything else.
- Mid-word reset: the word in flight is discarded. No partial completion and no done pulse.
- States:
  - IDLE: valid=0, SDO=0.
  - SHIFT: one serial bit per cycle.
- Counter: bit counter, width clog2(WIDTH+1).
- ready = (state==IDLE) | done.
- Accept: load & ready at a rising edge.
  - Shift register <= din.
  - SDO <= din[0], valid <= 1, counter <= WIDTH-1, state <= SHIFT.
  - Latency: first bit appears on SDO in the cycle after the accepting edge.
- SHIFT, counter>0:
  - SDO <= next LSB (shift register shifts right by 1, 0 enters the MSB).
  - counter decrements.
  - done <= 1 when counter becomes 0.
- SHIFT, counter==0 (last bit on the line, done=1):
  - If load=1: the new word is accepted at this edge, with no idle gap (back-to-back streaming). done is not reasserted until that new word's last bit.
  - Else: state <= IDLE, valid <= 0, SDO <= 0, done <= 0.
- load while busy (ready=0): ignored; din is not sampled.
- done is high for exactly one cycle per word unless words stream back-to-back. In that case it pulses once per word, every WIDTH cycles.
- din changes outside the accept edge have no effect.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra cycle drives the even-parity bit (XOR of the captured word) on SDO with valid=1.
  - done is asserted during the parity cycle instead of the last data bit.
  - The counter loads WIDTH instead of WIDTH-1.
  - Frame length is WIDTH+1 cycles; back-to-back acceptance occurs during the parity cycle.
- Undefined: no parity cycle; frame is exactly WIDTH cycles as described above.

Test Plan:
- Reset then idle: clrb=0 for 100 ns, then 1, load=0 -> SDO=0, valid=0, done=0, ready=1 throughout.
- Single word, WIDTH=4: load din=4'b1011 for one edge -> over the next 4 cycles SDO=1,1,0,1, valid=1 for all 4, done=1 only on the 4th, then valid=0. A right-shift receiver fed from SDO holds 4'b1011.
- Busy ignore: load din=4'hA, then hold load=1 with din=4'h5 during cycles 1-2 -> SDO=0,1,0,1 (4'hA unchanged). 4'h5 is accepted on the done edge, so SDO=1,0,1,0 follows immediately with no gap.
- Back-to-back: load held high, din=4'hF then 4'h0 -> 8 continuous valid cycles (SDO=1,1,1,1,0,0,0,0), done pulses at cycles 4 and 8.
- Mid-word reset: load din=4'hC, assert clrb=0 after 2 bits -> SDO, valid and done drop to 0 immediately. After release, ready=1 and no residual bits are emitted.
- PISO_PARITY_EN defined: load din=4'b0111 -> SDO=1,1,1,0 then parity bit 1; valid high 5 cycles, done only on the 5th.
